traffic_intersection_ctrl: RTL and testbench
============================================

Name: traffic_intersection_ctrl

Overview:
Parametrised two-road intersection controller, replacing the single-road green/yellow/red sequencer. Drives main-road and side-road lights and a pedestrian walk signal, with all-red clearance phases. Adds a latched pedestrian request that shortens main green after a minimum time, plus a maintenance flash mode. Generates its own 1 s tick enable (no derived clocks) and outputs a two-digit BCD countdown for the existing seven-segment decoder.

Parameters:
TICK_DIV, 125_000_000, clk cycles per tick (≥2)
T_MAIN_GREEN, 30, main green duration in ticks (1..99)
T_MIN_GREEN, 10, minimum main green before a pedestrian request may cut it (1..T_MAIN_GREEN)
T_SIDE_GREEN, 20, side green duration in ticks; walk is active during it (1..99)
T_YELLOW, 3, yellow duration in ticks (1..99)
T_ALL_RED, 1, all-red clearance duration in ticks (1..99)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ped_req  in  1  pedestrian button, level or pulse; sampled every clk
flash_mode  in  1  maintenance flash request, level
main_light  out  3  {G,Y,R}: 100 green, 010 yellow, 001 red, 000 dark
side_light  out  3  same encoding
walk_light  out  1  1 = walk permitted across main road
ped_wait  out  1  pedestrian request latched and pending
countdown_bcd  out  8  remaining ticks of current phase, {tens,units} BCD; 8'h00 in FLASH
phase  out  3  current state encoding, for debug/LEDs
tick  out  1  one-clk pulse at each tick

Behaviour:
- Prescaler: counts 0..TICK_DIV-1; tick=1 in the cycle it equals TICK_DIV-1, then wraps to 0. First tick after reset occurs at clk cycle TICK_DIV.
- States: MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, FLASH.
- Normal order: ALL_RED_B → MAIN_GREEN → MAIN_YELLOW → ALL_RED_A → SIDE_GREEN → SIDE_YELLOW → ALL_RED_B.
- remaining (7 bits): loaded with the phase duration on state entry. On a tick, if remaining==1 the FSM advances and loads the next duration; otherwise remaining decrements. Each phase therefore lasts exactly T ticks. remaining never reads 0 outside FLASH.
- Lights: MAIN_GREEN main=100 side=001. MAIN_YELLOW main=010 side=001. SIDE_GREEN main=001 side=100. SIDE_YELLOW main=001 side=010. ALL_RED_* both 001. walk_light=1 only in SIDE_GREEN.
- Pedestrian request:
  - ped_pending is set when ped_req=1 in any state except SIDE_GREEN and FLASH.
  - ped_pending is cleared on entry to SIDE_GREEN, on entry to FLASH, and by rst. ped_wait = ped_pending.
  - In MAIN_GREEN with ped_pending=1 and elapsed ticks ≥ T_MIN_GREEN (remaining ≤ T_MAIN_GREEN−T_MIN_GREEN), the next tick advances to MAIN_YELLOW.
  - A request during SIDE_GREEN is ignored, because walk is already active.
- Flash:
  - flash_mode=1 forces FLASH on the next clk edge from any state; it has priority over tick.
  - In FLASH: main_light and side_light are 010 on odd tick counts and 000 on even ones (a toggle flop, starting dark on entry); walk_light=0; remaining=0.
  - When flash_mode=0 in FLASH, the FSM enters ALL_RED_B on the next clk edge and loads T_ALL_RED.
- Reset state: state=ALL_RED_B, remaining=T_ALL_RED, prescaler=0, ped_pending=0, flash toggle=0. Outputs main=side=001, walk_light=0, ped_wait=0, tick=0, countdown_bcd=BCD(T_ALL_RED).
- Reset mid-phase: all state is discarded and the reset values are reapplied the next cycle.
- countdown_bcd: combinational binary-to-BCD of remaining (0..99). phase and lights are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Simultaneous events:
  - rst dominates everything.
  - flash_mode dominates tick and ped_req.
  - ped_req in the same cycle as the MAIN_GREEN cut-eligible tick does not cut on that tick; it cuts on the following tick.
- Parameter violations are caught by elaboration-time assertions.

Decomposition:
- Package tlc_pkg holds the state enum (phase_e), the light encoding constants (LIGHT_GREEN/YELLOW/RED/DARK) and the bcd_2digit function.
- Sub-module tick_gen (parametrised TICK_DIV, inputs clk and rst, output tick) replaces the divided-clock approach.
- FSM, remaining counter and ped latch stay in the top module.

Test Plan:
Params for all directed tests: TICK_DIV=4, T_MAIN_GREEN=6, T_MIN_GREEN=2, T_SIDE_GREEN=4, T_YELLOW=2, T_ALL_RED=1.
1. rst for 3 cycles, then idle → both lights 001, countdown 8'h01. MAIN_GREEN entered at clk 4 with countdown 8'h06. Full 16-tick cycle repeats every 64 clks; walk_light high for exactly 16 clks.
2. ped_req pulse 1 clk after MAIN_GREEN entry → ped_wait=1. MAIN_YELLOW entered after 2 ticks (countdown 06→05→yellow 02). walk rises when SIDE_GREEN is entered; ped_wait clears the same edge.
3. ped_req at remaining=1 of MAIN_GREEN → no shortening. Normal order proceeds and ped_wait clears at SIDE_GREEN.
4. ped_req during SIDE_GREEN → ped_wait stays 0, phase timing unchanged.
5. flash_mode=1 mid SIDE_GREEN → next clk phase=FLASH, walk=0, countdown 8'h00. Lights toggle 000↔010 each tick. Deassert → ALL_RED_B for 1 tick, then MAIN_GREEN.
6. rst asserted mid MAIN_YELLOW, 1 clk → next cycle reset values. First tick occurs 4 clks after rst is released.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the two-road traffic intersection controller.
// Contents: phase encoding (legacy constants plus phase_e), light encodings,
// the light bundle payload and a two-digit binary-to-BCD helper.
package tlc_pkg;

   // Phase codes kept as plain constants so legacy LED decoding stays stable
   localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
   localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
   localparam logic [2:0] ST_ALL_RED_A   = 3'd2;
   localparam logic [2:0] ST_SIDE_GREEN  = 3'd3;
   localparam logic [2:0] ST_SIDE_YELLOW = 3'd4;
   localparam logic [2:0] ST_ALL_RED_B   = 3'd5;
   localparam logic [2:0] ST_FLASH       = 3'd6;

   typedef enum logic [2:0] {
      PH_MAIN_GREEN  = ST_MAIN_GREEN,
      PH_MAIN_YELLOW = ST_MAIN_YELLOW,
      PH_ALL_RED_A   = ST_ALL_RED_A,
      PH_SIDE_GREEN  = ST_SIDE_GREEN,
      PH_SIDE_YELLOW = ST_SIDE_YELLOW,
      PH_ALL_RED_B   = ST_ALL_RED_B,
      PH_FLASH       = ST_FLASH
   } phase_e;

   // Lamp encoding {G,Y,R}
   localparam logic [2:0] LIGHT_GREEN  = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_RED    = 3'b001;
   localparam logic [2:0] LIGHT_DARK   = 3'b000;

   localparam int unsigned REM_W = 7;

   // Everything the lamp drivers need in one registered bundle
   typedef struct packed {
      logic [2:0] main;
      logic [2:0] side;
      logic       walk;
   } lights_t;

   // Binary 0..99 to {tens,units} BCD
   function automatic logic [7:0] bcd_2digit(input logic [REM_W-1:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-clk tick enable every TICK_DIV cycles.
// Ports: clk, rst (sync, active-high), tick_o (registered, high while the
// count sits at TICK_DIV-1; first occurrence TICK_DIV cycles after reset).
module tick_gen #(
   parameter int unsigned TICK_DIV = 125_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Wrap counter; tick is registered alongside so it tracks cnt_q == LAST
   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tick_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: main/side lights, pedestrian walk with a
// latched request that can shorten main green, all-red clearances, and a
// maintenance flash mode. Timing is in ticks from an internal prescaler.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ped_req_i         pedestrian button (level or pulse)
//   flash_mode_i      maintenance flash request (level)
//   main_light_o      main-road lamps {G,Y,R}
//   side_light_o      side-road lamps {G,Y,R}
//   walk_light_o      walk permitted across main road
//   ped_wait_o        pedestrian request pending
//   countdown_bcd_o   remaining ticks of phase, {tens,units}; 0 in flash
//   phase_o           current phase code
//   tick_o            one-clk tick pulse
module traffic_intersection_ctrl
   import tlc_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 125_000_000,
   parameter int unsigned T_MAIN_GREEN = 30,
   parameter int unsigned T_MIN_GREEN  = 10,
   parameter int unsigned T_SIDE_GREEN = 20,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_ALL_RED    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req_i,
   input  logic       flash_mode_i,
   output logic [2:0] main_light_o,
   output logic [2:0] side_light_o,
   output logic       walk_light_o,
   output logic       ped_wait_o,
   output logic [7:0] countdown_bcd_o,
   output logic [2:0] phase_o,
   output logic       tick_o
);

   // Parameter sanity at elaboration
   if (TICK_DIV < 2) begin : g_bad_div
      $error("TICK_DIV must be >= 2");
   end
   if (T_MAIN_GREEN < 1 || T_MAIN_GREEN > 99) begin : g_bad_main
      $error("T_MAIN_GREEN out of range 1..99");
   end
   if (T_MIN_GREEN < 1 || T_MIN_GREEN > T_MAIN_GREEN) begin : g_bad_min
      $error("T_MIN_GREEN out of range 1..T_MAIN_GREEN");
   end
   if (T_SIDE_GREEN < 1 || T_SIDE_GREEN > 99) begin : g_bad_side
      $error("T_SIDE_GREEN out of range 1..99");
   end
   if (T_YELLOW < 1 || T_YELLOW > 99) begin : g_bad_yel
      $error("T_YELLOW out of range 1..99");
   end
   if (T_ALL_RED < 1 || T_ALL_RED > 99) begin : g_bad_red
      $error("T_ALL_RED out of range 1..99");
   end

   localparam logic [REM_W-1:0] D_MAIN_GREEN = REM_W'(T_MAIN_GREEN);
   localparam logic [REM_W-1:0] D_SIDE_GREEN = REM_W'(T_SIDE_GREEN);
   localparam logic [REM_W-1:0] D_YELLOW     = REM_W'(T_YELLOW);
   localparam logic [REM_W-1:0] D_ALL_RED    = REM_W'(T_ALL_RED);
   // A cut is taken on the tick that completes T_MIN_GREEN ticks of green
   localparam logic [REM_W-1:0] CUT_AT       = REM_W'(T_MAIN_GREEN - T_MIN_GREEN + 1);

   phase_e            state_q, state_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic              ped_q, ped_d;
   logic              tog_q, tog_d;
   lights_t           lt_q, lt_d;
   logic [7:0]        cd_q, cd_d;
   logic              tick;
   logic              cut;
   phase_e            nxt;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   // Normal phase order
   function automatic phase_e next_phase(input phase_e s);
      case (s)
         PH_MAIN_GREEN:  return PH_MAIN_YELLOW;
         PH_MAIN_YELLOW: return PH_ALL_RED_A;
         PH_ALL_RED_A:   return PH_SIDE_GREEN;
         PH_SIDE_GREEN:  return PH_SIDE_YELLOW;
         PH_SIDE_YELLOW: return PH_ALL_RED_B;
         default:        return PH_MAIN_GREEN;
      endcase
   endfunction

   // Tick count loaded on entry to each phase
   function automatic logic [REM_W-1:0] duration(input phase_e s);
      case (s)
         PH_MAIN_GREEN:  return D_MAIN_GREEN;
         PH_MAIN_YELLOW: return D_YELLOW;
         PH_ALL_RED_A:   return D_ALL_RED;
         PH_SIDE_GREEN:  return D_SIDE_GREEN;
         PH_SIDE_YELLOW: return D_YELLOW;
         PH_ALL_RED_B:   return D_ALL_RED;
         default:        return '0;
      endcase
   endfunction

   // Lamp decode of a phase; in flash the toggle selects yellow or dark
   function automatic lights_t lights_of(input phase_e s, input logic tog);
      lights_t l;
      l = '{main: LIGHT_RED, side: LIGHT_RED, walk: 1'b0};
      case (s)
         PH_MAIN_GREEN:  l.main = LIGHT_GREEN;
         PH_MAIN_YELLOW: l.main = LIGHT_YELLOW;
         PH_SIDE_GREEN:  begin
            l.side = LIGHT_GREEN;
            l.walk = 1'b1;
         end
         PH_SIDE_YELLOW: l.side = LIGHT_YELLOW;
         PH_FLASH:       begin
            l.main = tog ? LIGHT_YELLOW : LIGHT_DARK;
            l.side = tog ? LIGHT_YELLOW : LIGHT_DARK;
         end
         default:        ;
      endcase
      return l;
   endfunction

   // Next-state, counter, pedestrian latch and flash toggle
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      ped_d   = ped_q;
      tog_d   = tog_q;
      nxt     = next_phase(state_q);
      cut     = (state_q == PH_MAIN_GREEN) && ped_q && (rem_q <= CUT_AT);

      if (flash_mode_i) begin
         state_d = PH_FLASH;
         rem_d   = '0;
      end else if (state_q == PH_FLASH) begin
         state_d = PH_ALL_RED_B;
         rem_d   = D_ALL_RED;
      end else if (tick) begin
         if (rem_q == REM_W'(1) || cut) begin
            state_d = nxt;
            rem_d   = duration(nxt);
         end else begin
            rem_d = rem_q - REM_W'(1);
         end
      end

      // Walk is already running in side green, so requests there are dropped
      if (ped_req_i && state_q != PH_SIDE_GREEN && state_q != PH_FLASH) begin
         ped_d = 1'b1;
      end
      if (state_d != state_q &&
          (state_d == PH_SIDE_GREEN || state_d == PH_FLASH)) begin
         ped_d = 1'b0;
      end

      // Held low outside flash so every flash entry starts dark
      if (state_q != PH_FLASH) begin
         tog_d = 1'b0;
      end else if (tick) begin
         tog_d = ~tog_q;
      end

      lt_d = lights_of(state_d, tog_d);
      cd_d = bcd_2digit(rem_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PH_ALL_RED_B;
         rem_q   <= D_ALL_RED;
         ped_q   <= 1'b0;
         tog_q   <= 1'b0;
         lt_q    <= '{main: LIGHT_RED, side: LIGHT_RED, walk: 1'b0};
         cd_q    <= bcd_2digit(D_ALL_RED);
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         ped_q   <= ped_d;
         tog_q   <= tog_d;
         lt_q    <= lt_d;
         cd_q    <= cd_d;
      end
   end

   assign main_light_o    = lt_q.main;
   assign side_light_o    = lt_q.side;
   assign walk_light_o    = lt_q.walk;
   assign ped_wait_o      = ped_q;
   assign countdown_bcd_o = cd_q;
   assign phase_o         = state_q;
   assign tick_o          = tick;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with small timing parameters.
module tb_traffic_intersection_ctrl;
   import tlc_pkg::*;

   logic       clk;
   logic       rst;
   logic       ped_req_i;
   logic       flash_mode_i;
   logic [2:0] main_light_o;
   logic [2:0] side_light_o;
   logic       walk_light_o;
   logic       ped_wait_o;
   logic [7:0] countdown_bcd_o;
   logic [2:0] phase_o;
   logic       tick_o;

   int n_vec = 0;
   int n_bad = 0;
   int t     = 0;
   int wcnt  = 0;

   traffic_intersection_ctrl #(
      .TICK_DIV     (4),
      .T_MAIN_GREEN (6),
      .T_MIN_GREEN  (2),
      .T_SIDE_GREEN (4),
      .T_YELLOW     (2),
      .T_ALL_RED    (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ped_req_i       (ped_req_i),
      .flash_mode_i    (flash_mode_i),
      .main_light_o    (main_light_o),
      .side_light_o    (side_light_o),
      .walk_light_o    (walk_light_o),
      .ped_wait_o      (ped_wait_o),
      .countdown_bcd_o (countdown_bcd_o),
      .phase_o         (phase_o),
      .tick_o          (tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
      t += n;
   endtask

   task automatic goto(input int e);
      adv(e - t);
   endtask

   // Three reset edges; t=0 is just after the last one
   task automatic do_reset();
      rst = 1'b1;
      adv(3);
      rst = 1'b0;
      t   = 0;
   endtask

   task automatic chk_phase(input string tag, input phase_e p, input logic [7:0] cd);
      chk({tag, "_phase"}, 8'(phase_o), 8'(p));
      chk({tag, "_cd"}, countdown_bcd_o, cd);
   endtask

   initial begin
      rst = 1'b1; ped_req_i = 1'b0; flash_mode_i = 1'b0;

      // 1: reset state and normal cycle
      do_reset();
      chk("rst_main", 8'(main_light_o), 8'(LIGHT_RED));
      chk("rst_side", 8'(side_light_o), 8'(LIGHT_RED));
      chk("rst_walk", 8'(walk_light_o), 8'd0);
      chk("rst_pedw", 8'(ped_wait_o), 8'd0);
      chk("rst_tick", 8'(tick_o), 8'd0);
      chk_phase("rst", PH_ALL_RED_B, 8'h01);
      goto(2);  chk("tick_c2", 8'(tick_o), 8'd0);
      goto(3);  chk("tick_c3", 8'(tick_o), 8'd1);
      goto(4);  chk("tick_c4", 8'(tick_o), 8'd0);
      chk_phase("mg_entry", PH_MAIN_GREEN, 8'h06);
      chk("mg_main", 8'(main_light_o), 8'(LIGHT_GREEN));
      chk("mg_side", 8'(side_light_o), 8'(LIGHT_RED));
      goto(8);  chk_phase("mg_dec", PH_MAIN_GREEN, 8'h05);
      goto(27); chk_phase("mg_last", PH_MAIN_GREEN, 8'h01);
      goto(28); chk_phase("my", PH_MAIN_YELLOW, 8'h02);
      chk("my_main", 8'(main_light_o), 8'(LIGHT_YELLOW));
      goto(36); chk_phase("ara", PH_ALL_RED_A, 8'h01);
      chk("ara_main", 8'(main_light_o), 8'(LIGHT_RED));
      goto(40); chk_phase("sg", PH_SIDE_GREEN, 8'h04);
      chk("sg_side", 8'(side_light_o), 8'(LIGHT_GREEN));
      chk("sg_walk", 8'(walk_light_o), 8'd1);
      goto(56); chk_phase("sy", PH_SIDE_YELLOW, 8'h02);
      chk("sy_side", 8'(side_light_o), 8'(LIGHT_YELLOW));
      chk("sy_walk", 8'(walk_light_o), 8'd0);
      goto(64); chk_phase("arb", PH_ALL_RED_B, 8'h01);
      goto(68); chk_phase("mg2", PH_MAIN_GREEN, 8'h06);
      wcnt = 0;
      for (int i = 0; i < 64; i++) begin
         adv(1);
         if (walk_light_o) wcnt++;
      end
      chk("walk_clks", 8'(wcnt), 8'd16);
      chk_phase("mg3", PH_MAIN_GREEN, 8'h06);

      // 2: request shortly after main green entry cuts after 2 ticks
      do_reset();
      goto(5);  ped_req_i = 1'b1;
      goto(6);  ped_req_i = 1'b0;
      chk("cut_pedw", 8'(ped_wait_o), 8'd1);
      goto(8);  chk_phase("cut_t1", PH_MAIN_GREEN, 8'h05);
      goto(11); chk_phase("cut_pre", PH_MAIN_GREEN, 8'h05);
      goto(12); chk_phase("cut_my", PH_MAIN_YELLOW, 8'h02);
      goto(23); chk("cut_walk0", 8'(walk_light_o), 8'd0);
      chk("cut_pedw1", 8'(ped_wait_o), 8'd1);
      goto(24); chk("cut_walk1", 8'(walk_light_o), 8'd1);
      chk("cut_pedw0", 8'(ped_wait_o), 8'd0);
      chk_phase("cut_sg", PH_SIDE_GREEN, 8'h04);

      // 2b: request together with a cut-eligible tick cuts one tick later
      do_reset();
      goto(11); ped_req_i = 1'b1;
      goto(12); ped_req_i = 1'b0;
      chk_phase("sim_nocut", PH_MAIN_GREEN, 8'h04);
      chk("sim_pedw", 8'(ped_wait_o), 8'd1);
      goto(16); chk_phase("sim_cut", PH_MAIN_YELLOW, 8'h02);

      // 3: request at remaining==1 does not shorten anything
      do_reset();
      goto(25); ped_req_i = 1'b1;
      goto(26); ped_req_i = 1'b0;
      chk("r1_pedw", 8'(ped_wait_o), 8'd1);
      goto(27); chk_phase("r1_mg", PH_MAIN_GREEN, 8'h01);
      goto(28); chk_phase("r1_my", PH_MAIN_YELLOW, 8'h02);
      goto(39); chk("r1_pedw1", 8'(ped_wait_o), 8'd1);
      goto(40); chk("r1_pedw0", 8'(ped_wait_o), 8'd0);
      chk_phase("r1_sg", PH_SIDE_GREEN, 8'h04);

      // 4: request during side green is ignored
      goto(41); ped_req_i = 1'b1;
      goto(45); ped_req_i = 1'b0;
      goto(46); chk("sgreq_pedw", 8'(ped_wait_o), 8'd0);
      goto(55); chk_phase("sgreq_sg", PH_SIDE_GREEN, 8'h01);
      goto(56); chk_phase("sgreq_sy", PH_SIDE_YELLOW, 8'h02);
      chk("sgreq_pedw2", 8'(ped_wait_o), 8'd0);

      // 5: flash from mid side green
      goto(105); flash_mode_i = 1'b1;
      goto(106); chk_phase("fl_entry", PH_FLASH, 8'h00);
      chk("fl_walk", 8'(walk_light_o), 8'd0);
      chk("fl_main0", 8'(main_light_o), 8'(LIGHT_DARK));
      chk("fl_side0", 8'(side_light_o), 8'(LIGHT_DARK));
      goto(107); chk("fl_main1", 8'(main_light_o), 8'(LIGHT_DARK));
      goto(108); chk("fl_main2", 8'(main_light_o), 8'(LIGHT_YELLOW));
      chk("fl_side2", 8'(side_light_o), 8'(LIGHT_YELLOW));
      goto(112); chk("fl_main3", 8'(main_light_o), 8'(LIGHT_DARK));
      goto(116); chk("fl_main4", 8'(main_light_o), 8'(LIGHT_YELLOW));
      goto(117); flash_mode_i = 1'b0;
      goto(118); chk_phase("fl_arb", PH_ALL_RED_B, 8'h01);
      chk("fl_arb_main", 8'(main_light_o), 8'(LIGHT_RED));
      goto(119); chk_phase("fl_arb2", PH_ALL_RED_B, 8'h01);
      goto(120); chk_phase("fl_mg", PH_MAIN_GREEN, 8'h06);

      // 6: reset during main yellow
      goto(144); chk_phase("mr_my", PH_MAIN_YELLOW, 8'h02);
      ped_req_i = 1'b1;
      goto(145); ped_req_i = 1'b0;
      chk("mr_pedw1", 8'(ped_wait_o), 8'd1);
      rst = 1'b1;
      goto(146); rst = 1'b0;
      chk_phase("mr_rst", PH_ALL_RED_B, 8'h01);
      chk("mr_main", 8'(main_light_o), 8'(LIGHT_RED));
      chk("mr_pedw0", 8'(ped_wait_o), 8'd0);
      chk("mr_tick", 8'(tick_o), 8'd0);
      goto(148); chk("mr_tick2", 8'(tick_o), 8'd0);
      goto(149); chk("mr_tick3", 8'(tick_o), 8'd1);
      goto(150); chk_phase("mr_mg", PH_MAIN_GREEN, 8'h06);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
